// File: rtl/mem_stage.sv
// Memory-access stage: byte-addressed little-endian data memory with wrapping
// multi-byte loads/stores, conditional branch resolution and event counters.
module mem_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addsum,
  input  logic [63:0] alu_res,
  input  logic        zero,
  input  logic        is_greater,
  input  logic [63:0] write_data,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        branch,
  input  logic [3:0]  func,
  output logic [63:0] read_data,
  output logic        pc_src,
  output logic [63:0] branch_target,
  output logic        flush,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] taken_count
);

  logic [7:0]    mem [DEPTH];
  logic [2:0]    funct3;
  logic [AW-1:0] base;
  logic [AW-1:0] idx [8];
  logic [63:0]   raw;
  logic [7:0]    byte_en;
  logic          load_valid;
  logic          store_valid;
  logic          taken;

  assign funct3      = func[2:0];
  assign base        = alu_res[AW-1:0];
  assign load_valid  = memread && (funct3 != 3'b111);
  assign store_valid = memwrite && !funct3[2];

  // Bits that do not take part in this stage; the name keeps lint quiet.
  logic unused_bits;
  assign unused_bits = &{1'b0, func[3], alu_res[63:AW]};

  // Byte lane i of an access sits at base+i; the AW-bit add wraps mod DEPTH.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      idx[i]         = base + AW'(i);
      raw[8*i +: 8]  = mem[idx[i]];
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    read_data = '0;
    if (memread && !reset) begin
      unique case (funct3)
        3'b000:  read_data = {{56{raw[7]}},  raw[7:0]};
        3'b001:  read_data = {{48{raw[15]}}, raw[15:0]};
        3'b010:  read_data = {{32{raw[31]}}, raw[31:0]};
        3'b011:  read_data = raw;
        3'b100:  read_data = {56'b0, raw[7:0]};
        3'b101:  read_data = {48'b0, raw[15:0]};
        3'b110:  read_data = {32'b0, raw[31:0]};
        default: read_data = '0;
      endcase
    end
  end

  always_comb begin
    byte_en = '0;
    if (store_valid) begin
      unique case (funct3[1:0])
        2'b00:   byte_en = 8'h01;
        2'b01:   byte_en = 8'h03;
        2'b10:   byte_en = 8'h0F;
        default: byte_en = 8'hFF;
      endcase
    end
  end

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:          taken = zero;
      3'b001:          taken = !zero;
      3'b100, 3'b110:  taken = !zero && !is_greater;
      3'b101, 3'b111:  taken = zero || is_greater;
      default:         taken = 1'b0;
    endcase
  end

  assign pc_src        = branch && taken && !reset;
  assign flush         = pc_src;
  assign branch_target = addsum;

  // NOTE: the memory is built from resettable flops because every byte must
  // read as zero after reset; a RAM macro without clear could not do that.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      load_count  <= '0;
      store_count <= '0;
      taken_count <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (byte_en[i]) mem[idx[i]] <= write_data[8*i +: 8];
      end
      if (load_valid)  load_count  <= load_count + 32'd1;
      if (store_valid) store_count <= store_count + 32'd1;
      if (pc_src)      taken_count <= taken_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads/stores, wrap-around,
// branch matrix, same-cycle read/write, reset priority and invalid encodings.
module tb_mem_stage;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addsum, alu_res, write_data;
  logic        zero, is_greater, memread, memwrite, branch;
  logic [3:0]  func;
  logic [63:0] read_data, branch_target;
  logic        pc_src, flush;
  logic [31:0] load_count, store_count, taken_count;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addsum(addsum), .alu_res(alu_res),
    .zero(zero), .is_greater(is_greater), .write_data(write_data),
    .memread(memread), .memwrite(memwrite), .branch(branch), .func(func),
    .read_data(read_data), .pc_src(pc_src), .branch_target(branch_target),
    .flush(flush), .load_count(load_count), .store_count(store_count),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation just after a rising edge, then wait for the falling edge.
  task automatic op(input logic rd, input logic wr, input logic br,
                    input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    @(posedge clk);
    #1;
    memread    = rd;
    memwrite   = wr;
    branch     = br;
    func       = {1'b0, f3};
    alu_res    = a;
    write_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
  endtask

  initial begin
    reset = 1'b1; addsum = 64'h400; alu_res = '0; write_data = '0;
    zero = 1'b0; is_greater = 1'b0; memread = 1'b0; memwrite = 1'b0;
    branch = 1'b0; func = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_read_data", read_data, 64'h0);
    check("reset_load_count", {32'h0, load_count}, 64'h0);
    check("reset_store_count", {32'h0, store_count}, 64'h0);
    check("reset_taken_count", {32'h0, taken_count}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Store then load back
    op(1'b0, 1'b1, 1'b0, 3'b011, 64'h10, 64'h8877665544332211);
    op(1'b1, 1'b0, 1'b0, 3'b011, 64'h10, 64'h0);
    check("ld_0x10", read_data, 64'h8877665544332211);
    op(1'b1, 1'b0, 1'b0, 3'b000, 64'h17, 64'h0);
    check("lb_0x17", read_data, 64'hFFFFFFFFFFFFFF88);
    op(1'b1, 1'b0, 1'b0, 3'b100, 64'h17, 64'h0);
    check("lbu_0x17", read_data, 64'h88);
    op(1'b1, 1'b0, 1'b0, 3'b101, 64'h16, 64'h0);
    check("lhu_0x16", read_data, 64'h8877);
    idle();
    check("store_count_1", {32'h0, store_count}, 64'd1);
    check("load_count_4", {32'h0, load_count}, 64'd4);
    check("idle_read_data", read_data, 64'h0);

    // Wrap-around store and loads
    op(1'b0, 1'b1, 1'b0, 3'b010, 64'(DEPTH - 2), 64'h11223344DDCCBBAA);
    op(1'b1, 1'b0, 1'b0, 3'b010, 64'(DEPTH - 2), 64'h0);
    check("lw_wrap", read_data, 64'hFFFFFFFFDDCCBBAA);
    op(1'b1, 1'b0, 1'b0, 3'b100, 64'(DEPTH - 1), 64'h0);
    check("lbu_last", read_data, 64'hBB);
    op(1'b1, 1'b0, 1'b0, 3'b011, 64'h0, 64'h0);
    check("ld_0_wrapped_bytes", read_data, 64'hDDCC);
    op(1'b1, 1'b0, 1'b0, 3'b110, 64'h1000 + 64'(DEPTH - 2), 64'h0);
    check("lwu_high_addr_bits_ignored", read_data, 64'hDDCCBBAA);

    // Branch matrix
    zero = 1'b1; is_greater = 1'b0;
    op(1'b0, 1'b0, 1'b1, 3'b000, 64'h0, 64'h0);
    check("beq_taken_pc_src", {63'h0, pc_src}, 64'd1);
    check("beq_taken_flush", {63'h0, flush}, 64'd1);
    check("beq_target", branch_target, 64'h400);
    op(1'b0, 1'b0, 1'b1, 3'b001, 64'h0, 64'h0);
    check("bne_not_taken", {63'h0, pc_src}, 64'd0);
    op(1'b0, 1'b0, 1'b1, 3'b010, 64'h0, 64'h0);
    check("f3_010_never_taken", {63'h0, pc_src}, 64'd0);
    zero = 1'b0;
    op(1'b0, 1'b0, 1'b1, 3'b100, 64'h0, 64'h0);
    check("blt_taken", {63'h0, pc_src}, 64'd1);
    op(1'b0, 1'b0, 1'b1, 3'b101, 64'h0, 64'h0);
    check("bge_not_taken", {63'h0, pc_src}, 64'd0);
    op(1'b0, 1'b0, 1'b0, 3'b100, 64'h0, 64'h0);
    check("no_branch_pc_src", {63'h0, pc_src}, 64'd0);
    check("taken_count_2", {32'h0, taken_count}, 64'd2);

    // Same-cycle read and write
    op(1'b1, 1'b1, 1'b0, 3'b011, 64'h20, 64'h1234);
    check("rw_same_cycle_old_data", read_data, 64'h0);
    op(1'b1, 1'b0, 1'b0, 3'b011, 64'h20, 64'h0);
    check("ld_after_rw", read_data, 64'h1234);

    // Invalid encodings
    op(1'b0, 1'b1, 1'b0, 3'b100, 64'h10, 64'hFFFFFFFFFFFFFFFF);
    op(1'b1, 1'b0, 1'b0, 3'b011, 64'h10, 64'h0);
    check("invalid_store_no_write", read_data, 64'h8877665544332211);
    check("invalid_store_count", {32'h0, store_count}, 64'd3);
    op(1'b1, 1'b0, 1'b0, 3'b111, 64'h10, 64'h0);
    check("f3_111_load_zero", read_data, 64'h0);
    idle();
    check("invalid_load_count", {32'h0, load_count}, 64'd11);

    // Reset in the middle of a sequence
    op(1'b0, 1'b1, 1'b0, 3'b000, 64'h30, 64'h11);
    op(1'b1, 1'b0, 1'b0, 3'b100, 64'h30, 64'h0);
    check("lbu_0x30_pre_reset", read_data, 64'h11);
    @(posedge clk);
    #1;
    reset = 1'b1; zero = 1'b1;
    memread = 1'b1; memwrite = 1'b1; branch = 1'b1; func = 4'b0000;
    alu_res = 64'h30; write_data = 64'h5A;
    @(negedge clk);
    check("reset_masks_read_data", read_data, 64'h0);
    check("reset_masks_pc_src", {63'h0, pc_src}, 64'd0);
    check("reset_masks_flush", {63'h0, flush}, 64'd0);
    check("reset_target_passthrough", branch_target, 64'h400);
    @(posedge clk);
    #1;
    reset = 1'b0; zero = 1'b0;
    memread = 1'b0; memwrite = 1'b0; branch = 1'b0;
    @(negedge clk);
    check("post_reset_load_count", {32'h0, load_count}, 64'd0);
    check("post_reset_store_count", {32'h0, store_count}, 64'd0);
    check("post_reset_taken_count", {32'h0, taken_count}, 64'd0);
    op(1'b1, 1'b0, 1'b0, 3'b100, 64'h30, 64'h0);
    check("mem_0x30_cleared", read_data, 64'h0);
    op(1'b1, 1'b0, 1'b0, 3'b011, 64'h10, 64'h0);
    check("mem_0x10_cleared", read_data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit RISC-V pipeline. It consumes the outputs of the EX/MEM pipeline register and performs loads and stores against a byte-addressed data memory. It also resolves conditional branches and produces the load data and branch redirect for the MEM/WB register and the fetch unit. Per-stage event counters give the bench and debug logic visibility into memory and branch traffic.

## Interface
Parameters:
- DEPTH, 256: data memory size in bytes; power of two, at least 8.
- AW, log2(DEPTH): byte-address bits used for indexing.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addsum  input  64  branch target from EX/MEM.
- alu_res  input  64  effective address for loads and stores.
- zero  input  1  ALU zero flag (rs1 == rs2).
- is_greater  input  1  signed rs1 > rs2 from EX.
- write_data  input  64  store data, already forwarded.
- memread, memwrite, branch  input  1 each  control bits from EX/MEM.
- func  input  4  {instr[30], funct3}; only funct3 = func[2:0] is used here.
- read_data  output  64  extended load result, combinational.
- pc_src  output  1  branch taken; select addsum at fetch.
- branch_target  output  64  equals addsum.
- flush  output  1  equals pc_src; squashes IF/ID, ID/EX and EX/MEM.
- load_count, store_count, taken_count  output  32 each  event counters.

## Operation
Memory indexing:
- The byte array is mem[0..DEPTH-1], little-endian.
- An access of N bytes touches (alu_res + i) mod DEPTH for i = 0..N-1. Only the low AW bits of the address are used.
- Unaligned accesses are legal, and an access that runs past the last byte wraps to byte 0.

Load, when memread = 1. The access size and extension depend on funct3:
- 000 lb: 1 byte, sign-extended.
- 001 lh: 2 bytes, sign-extended.
- 010 lw: 4 bytes, sign-extended.
- 011 ld: 8 bytes.
- 100 lbu: 1 byte, zero-extended.
- 101 lhu: 2 bytes, zero-extended.
- 110 lwu: 4 bytes, zero-extended.
- 111: read_data = 0.
- When memread = 0, read_data = 0.

Store, when memwrite = 1. The low bytes of write_data are written at the clock edge:
- 000: sb, 1 byte.
- 001: sh, 2 bytes.
- 010: sw, 4 bytes.
- 011: sd, 8 bytes.
- 1xx: no write.

Branch resolution, when branch = 1:
- 000 beq: taken if zero.
- 001 bne: taken if !zero.
- 100 blt: taken if !zero & !is_greater.
- 101 bge: taken if zero | is_greater.
- 110 and 111 use the same conditions as 100 and 101 (unsigned compare is done upstream in is_greater).
- 010 and 011: never taken.
- pc_src = branch & taken.
- When branch = 0, pc_src = 0.

Counters, each incrementing by 1 per clock when its condition holds:
- load_count: valid load (memread with funct3 != 111).
- store_count: valid store (memwrite with funct3[2] = 0).
- taken_count: pc_src = 1.
- All counters wrap from 0xFFFFFFFF to 0.

## Timing
- read_data, pc_src, flush and branch_target are combinational from the current inputs and memory contents: zero-cycle latency.
- Store bytes commit at the rising edge that ends the cycle in which memwrite = 1. A load in the following cycle sees the new data.
- If memread and memwrite are both 1 in the same cycle, read_data returns the pre-write contents and the write still commits.
- Reset, sampled at a rising edge with reset = 1:
  - All DEPTH bytes of memory clear to 0.
  - All three counters clear to 0.
  - Any store or count presented in that cycle is discarded; reset has priority.
- While reset = 1, read_data = 0, pc_src = 0 and flush = 0, regardless of the other inputs.
- Reset asserted in the middle of an instruction sequence loses only the in-flight access. There is no partial multi-byte write: either all bytes of a store commit or none do.
- branch_target = addsum at all times, including during reset.

## Test plan
- Store then load back. sd with alu_res = 0x10 and write_data = 0x8877665544332211, then ld from 0x10 gives read_data = 0x8877665544332211. lb from 0x17 gives 0xFFFFFFFFFFFFFF88. lbu from 0x17 gives 0x88. lhu from 0x16 gives 0x8877. store_count = 1 and load_count = 4.
- Wrap-around store. sw with alu_res = DEPTH-2 and write_data = 0xDDCCBBAA writes mem[DEPTH-2] = 0xAA, mem[DEPTH-1] = 0xBB, mem[0] = 0xCC and mem[1] = 0xDD. lw from DEPTH-2 gives 0xFFFFFFFFDDCCBBAA.
- Branch matrix, with addsum = 0x400 throughout:
  - beq with zero = 1 gives pc_src = flush = 1 and branch_target = 0x400.
  - bne with zero = 1 gives pc_src = 0.
  - blt with zero = 0 and is_greater = 0 gives pc_src = 1.
  - bge with zero = 0 and is_greater = 0 gives pc_src = 0.
  - After these, taken_count = 2.
- Same-cycle read and write. Start with mem[0x20..0x27] = 0. Apply memread = memwrite = 1 with sd at 0x20 of 0x1234: read_data = 0 in that cycle. The next cycle's ld from 0x20 gives 0x1234.
- Reset in the middle of a sequence. Assert reset in the same cycle as an sb of 0x5A to 0x30. After the edge, mem[0x30] = 0 and all counters = 0. While reset = 1, read_data, pc_src and flush are 0 even with branch = 1 and zero = 1 applied.
- Invalid encodings. memwrite with funct3 = 100 leaves memory unchanged and store_count unchanged. memread with funct3 = 111 gives read_data = 0 and load_count unchanged.
